// File: rtl/hub75_bcm_masked.sv
// HUB75 binary-coded-modulation row sequencer with a per-plane enable mask.
// For each enabled plane of a row: shift, wait for shift/blank engines,
// pre-latch delay, latch, post-latch delay, then blank-period kick-off.
module hub75_bcm_masked #(
  parameter  int unsigned N_ROWS     = 32,
  parameter  int unsigned N_PLANES   = 8,
  parameter  int unsigned TIMER_W    = 8,
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS),
  localparam int unsigned PLANE_W    = $clog2(N_PLANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  phy_addr_inc,
  output logic                  phy_addr_rst,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic                  phy_le,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [N_PLANES-1:0]   blank_plane,
  output logic                  blank_go,
  input  logic                  blank_rdy,
  input  logic [LOG_N_ROWS-1:0] ctrl_row,
  input  logic                  ctrl_row_first,
  input  logic                  ctrl_go,
  output logic                  ctrl_rdy,
  input  logic [N_PLANES-1:0]   cfg_plane_en,
  input  logic [TIMER_W-1:0]    cfg_pre_latch_len,
  input  logic [TIMER_W-1:0]    cfg_latch_len,
  input  logic [TIMER_W-1:0]    cfg_post_latch_len,
  output logic [PLANE_W-1:0]    stat_plane_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WAIT  = 3'd2,
    PRE   = 3'd3,
    LATCH = 3'd4,
    POST  = 3'd5,
    BLANK = 3'd6
  } state_t;

  state_t                state;
  logic [TIMER_W:0]      timer;
  logic [PLANE_W-1:0]    plane_idx;
  logic [N_PLANES-1:0]   plane_oh;
  logic [N_PLANES-1:0]   mask_q;
  logic [LOG_N_ROWS-1:0] row_q;
  logic                  row_first_q;
  logic                  first_plane_q;
  logic [1:0]            rst_sync;
  logic                  run;
  logic [PLANE_W:0]      first_pick;
  logic [PLANE_W:0]      next_pick;

  // Lowest set bit of mask at or above start; MSB of result flags "found".
  function automatic logic [PLANE_W:0] find_plane(input logic [N_PLANES-1:0] mask,
                                                  input int start);
    logic [PLANE_W:0] res;
    res = '0;
    for (int i = int'(N_PLANES) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) res = {1'b1, PLANE_W'(i)};
    end
    return res;
  endfunction

  assign first_pick = find_plane(cfg_plane_en, 0);
  assign next_pick  = find_plane(mask_q, int'(plane_idx) + 1);
  assign run        = rst_sync[1];

  assign shift_plane    = plane_oh;
  assign blank_plane    = plane_oh;
  assign stat_plane_idx = plane_idx;

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Sequencer FSM with registered pulse/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      plane_idx     <= '0;
      plane_oh      <= N_PLANES'(1);
      mask_q        <= '0;
      row_q         <= '0;
      row_first_q   <= 1'b0;
      first_plane_q <= 1'b0;
      phy_addr      <= '0;
      phy_addr_inc  <= 1'b0;
      phy_addr_rst  <= 1'b0;
      phy_le        <= 1'b0;
      shift_go      <= 1'b0;
      blank_go      <= 1'b0;
      ctrl_rdy      <= 1'b1;
    end else if (run) begin
      case (state)
        IDLE: begin
          if (ctrl_go) begin
            mask_q      <= cfg_plane_en;
            row_q       <= ctrl_row;
            row_first_q <= ctrl_row_first;
            if (first_pick[PLANE_W]) begin
              plane_idx     <= first_pick[PLANE_W-1:0];
              plane_oh      <= N_PLANES'(1) << first_pick[PLANE_W-1:0];
              first_plane_q <= 1'b1;
              shift_go      <= 1'b1;
              ctrl_rdy      <= 1'b0;
              state         <= SHIFT;
            end
          end
        end

        SHIFT: begin
          shift_go <= 1'b0;
          state    <= WAIT;
        end

        WAIT: begin
          if (shift_rdy && blank_rdy) begin
            timer <= {1'b0, cfg_pre_latch_len};
            state <= PRE;
          end
        end

        PRE: begin
          if (timer == '0) begin
            timer    <= {1'b0, cfg_latch_len};
            phy_le   <= 1'b1;
            phy_addr <= row_q;
            if (first_plane_q) begin
              phy_addr_rst <= row_first_q;
              phy_addr_inc <= ~row_first_q;
            end
            state <= LATCH;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        LATCH: begin
          if (timer == '0) begin
            timer         <= {1'b0, cfg_post_latch_len};
            phy_le        <= 1'b0;
            phy_addr_rst  <= 1'b0;
            phy_addr_inc  <= 1'b0;
            first_plane_q <= 1'b0;
            state         <= POST;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        POST: begin
          if (timer == '0) begin
            blank_go <= 1'b1;
            state    <= BLANK;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        BLANK: begin
          blank_go <= 1'b0;
          if (next_pick[PLANE_W]) begin
            plane_idx <= next_pick[PLANE_W-1:0];
            plane_oh  <= N_PLANES'(1) << next_pick[PLANE_W-1:0];
            shift_go  <= 1'b1;
            state     <= SHIFT;
          end else begin
            ctrl_rdy <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          ctrl_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_masked.sv
// Bench for hub75_bcm_masked: per-cycle comparison against an expected trace
// built from the plane/phase rules (shift, wait, pre, latch, post, blank).
module tb_hub75_bcm_masked;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phy_addr_inc, phy_addr_rst, phy_le;
  logic [4:0] phy_addr;
  logic [7:0] shift_plane, blank_plane;
  logic       shift_go, blank_go;
  logic       shift_rdy = 1'b1;
  logic       blank_rdy = 1'b1;
  logic [4:0] ctrl_row = '0;
  logic       ctrl_row_first = 1'b0;
  logic       ctrl_go = 1'b0;
  logic       ctrl_rdy;
  logic [7:0] cfg_plane_en = '0;
  logic [7:0] cfg_pre_latch_len = '0;
  logic [7:0] cfg_latch_len = '0;
  logic [7:0] cfg_post_latch_len = '0;
  logic [2:0] stat_plane_idx;

  hub75_bcm_masked dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .phy_addr_inc       (phy_addr_inc),
    .phy_addr_rst       (phy_addr_rst),
    .phy_addr           (phy_addr),
    .phy_le             (phy_le),
    .shift_plane        (shift_plane),
    .shift_go           (shift_go),
    .shift_rdy          (shift_rdy),
    .blank_plane        (blank_plane),
    .blank_go           (blank_go),
    .blank_rdy          (blank_rdy),
    .ctrl_row           (ctrl_row),
    .ctrl_row_first     (ctrl_row_first),
    .ctrl_go            (ctrl_go),
    .ctrl_rdy           (ctrl_rdy),
    .cfg_plane_en       (cfg_plane_en),
    .cfg_pre_latch_len  (cfg_pre_latch_len),
    .cfg_latch_len      (cfg_latch_len),
    .cfg_post_latch_len (cfg_post_latch_len),
    .stat_plane_idx     (stat_plane_idx)
  );

  always #5 clk = ~clk;

  // One expected cycle: v = {ctrl_rdy, shift_go, blank_go, phy_le, addr_rst, addr_inc}
  typedef struct {
    logic [5:0] v;
    int         plane;
    int         addr;
  } ev_t;

  ev_t tr[$];
  int  checks = 0;
  int  fails = 0;
  int  model_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [5:0] v, input int plane, input int addr);
    ev_t e;
    e.v = v;
    e.plane = plane;
    e.addr = addr;
    return e;
  endfunction

  // Expected per-cycle trace of one row, starting with the cycle after ctrl_go.
  task automatic build(input logic [7:0] mask, input int pre, input int lat, input int post,
                       input logic first, input int row, input int stall);
    bit first_done;
    first_done = 1'b0;
    tr.delete();
    for (int p = 0; p < 8; p++) begin
      if (mask[p]) begin
        tr.push_back(mk(6'b010000, p, model_addr));
        for (int w = 0; w < (first_done ? 1 : stall + 1); w++) tr.push_back(mk(6'b000000, p, model_addr));
        for (int c = 0; c <= pre; c++) tr.push_back(mk(6'b000000, p, model_addr));
        model_addr = row;
        for (int c = 0; c <= lat; c++)
          tr.push_back(mk({4'b0001, !first_done && first, !first_done && !first}, p, model_addr));
        for (int c = 0; c <= post; c++) tr.push_back(mk(6'b000000, p, model_addr));
        tr.push_back(mk(6'b001000, p, model_addr));
        first_done = 1'b1;
      end
    end
    for (int c = 0; c < ((mask == 8'h00) ? 20 : 2); c++) tr.push_back(mk(6'b100000, -1, model_addr));
  endtask

  // Launch one row and compare every cycle; optionally reset during LATCH of abort_plane.
  task automatic run_row(input logic [7:0] mask, input int pre, input int lat, input int post,
                         input logic first, input int row, input int stall, input int abort_plane);
    build(mask, pre, lat, post, first, row, stall);
    @(negedge clk);
    cfg_plane_en       = mask;
    cfg_pre_latch_len  = 8'(pre);
    cfg_latch_len      = 8'(lat);
    cfg_post_latch_len = 8'(post);
    ctrl_row           = 5'(row);
    ctrl_row_first     = first;
    shift_rdy          = (stall == 0);
    blank_rdy          = 1'b1;
    ctrl_go            = 1'b1;
    @(negedge clk);
    ctrl_go = 1'b0;
    foreach (tr[i]) begin
      chk("ctl", 32'({ctrl_rdy, shift_go, blank_go, phy_le, phy_addr_rst, phy_addr_inc}), 32'(tr[i].v));
      chk("addr", 32'(phy_addr), 32'(tr[i].addr));
      if (tr[i].plane >= 0) begin
        chk("plane_idx", 32'(stat_plane_idx), 32'(tr[i].plane));
        chk("shift_plane", 32'(shift_plane), 32'd1 << tr[i].plane);
        chk("blank_plane", 32'(blank_plane), 32'd1 << tr[i].plane);
      end
      if (abort_plane >= 0 && tr[i].v[2] && tr[i].plane == abort_plane) begin
        rst_n = 1'b0;
        #1;
        model_addr = 0;
        chk("abort_pulses", 32'({shift_go, blank_go, phy_le, phy_addr_rst, phy_addr_inc}), 32'd0);
        chk("abort_rdy", 32'(ctrl_rdy), 32'd1);
        chk("abort_idx", 32'(stat_plane_idx), 32'd0);
        chk("abort_addr", 32'(phy_addr), 32'd0);
        break;
      end
      // Mask changes mid-row must not matter; rdy held low for 'stall' WAIT cycles.
      cfg_plane_en = 8'($urandom);
      shift_rdy    = (i >= 1 + stall);
      blank_rdy    = (i >= 1 + stall) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pulses", 32'({shift_go, blank_go, phy_le, phy_addr_rst, phy_addr_inc}), 32'd0);
    chk("rst_rdy", 32'(ctrl_rdy), 32'd1);
    chk("rst_idx", 32'(stat_plane_idx), 32'd0);
    chk("rst_addr", 32'(phy_addr), 32'd0);

    // Release with ctrl_go already high: no state change on the first edge.
    cfg_plane_en = 8'h01;
    ctrl_row     = 5'd0;
    rst_n        = 1'b1;
    ctrl_go      = 1'b1;
    @(negedge clk);
    chk("sync_edge1_go", 32'(shift_go), 32'd0);
    chk("sync_edge1_rdy", 32'(ctrl_rdy), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (shift_go) seen = 1'b1;
    end
    ctrl_go = 1'b0;
    chk("sync_start_seen", 32'(seen), 32'd1);
    chk("sync_start_idx", 32'(stat_plane_idx), 32'd0);
    repeat (20) @(negedge clk);
    chk("sync_row_done", 32'(ctrl_rdy), 32'd1);

    // Full mask, lens 2/3/1, first row 5
    run_row(8'hFF, 2, 3, 1, 1'b1, 5, 0, -1);
    // Sparse mask, address increment
    run_row(8'h05, 1, 1, 1, 1'b0, 9, 0, -1);
    // Empty mask: nothing happens, address held
    run_row(8'h00, 1, 1, 1, 1'b1, 17, 0, -1);
    // Ready stall of 10 cycles with blank_rdy toggling
    run_row(8'h01, 0, 1, 0, 1'b0, 3, 10, -1);
    // Minimum and maximum phase lengths
    run_row(8'h02, 0, 255, 0, 1'b1, 7, 0, -1);
    run_row(8'h80, 255, 0, 255, 1'b0, 8, 0, -1);
    // Reset during LATCH of plane 3, then restart from plane 0
    run_row(8'hFF, 1, 2, 1, 1'b1, 12, 0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_row(8'hFF, 0, 0, 0, 1'b1, 4, 0, -1);

    // Randomized rows
    for (int r = 0; r < 8; r++) begin
      run_row(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
